// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    localparam logic [PC_W-1:0] PC_STEP      = 16'd2;
    localparam logic [PC_W-1:0] RESET_PC_DEF = 16'h0000;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instructions are halfword aligned, so the low address bit is always cleared.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small in-order queue of fetched entries with synchronous flush.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  fetch_entry_t               push_data_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            full_s;
    logic            empty_s;
    logic            do_push_s;
    logic            do_pop_s;

    assign full_s    = (cnt_q == CW'(DEPTH));
    assign empty_s   = (cnt_q == {CW{1'b0}});
    // A full queue may still accept a word when the head leaves in the same cycle.
    assign do_push_s = push_i & (~full_s | pop_i);
    assign do_pop_s  = pop_i & ~empty_s;

    // Next pointer and occupancy; a flush returns everything to the empty state.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = {PW{1'b0}};
            rd_d  = {PW{1'b0}};
            cnt_d = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_d = wr_q + PW'(1);
            end else begin
                wr_d = wr_q;
            end
            if (do_pop_s) begin
                rd_d = rd_q + PW'(1);
            end else begin
                rd_d = rd_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= {PW{1'b0}};
            rd_q  <= {PW{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s & ~flush_i) begin
            mem_q[wr_q] <= push_data_i;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = full_s;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, queues ROM words and hands them to decode.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEF,
    parameter int          QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_en,
    output logic [15:0]   imem_pc,
    input  logic [15:0]   imem_instr,
    input  logic          redirect_valid,
    input  logic [15:0]   redirect_pc,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [15:0]   id_instr,
    output logic [15:0]   id_pc
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic            pop_s;
    logic            push_s;
    logic            full_s;
    logic [CW-1:0]   count_s;
    fetch_entry_t    head_s;
    fetch_entry_t    push_entry_s;

    assign id_valid     = (count_s != {CW{1'b0}});
    assign pop_s        = id_valid & id_ready;
    // A redirect squashes any fetch in the same cycle; its address is stale.
    assign push_s       = fetch_en & ~redirect_valid & (~full_s | pop_s);
    assign push_entry_s = '{pc: pc_q, instr: imem_instr};

    // Next PC: redirect wins, otherwise step only when a word was accepted.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (push_s) begin
            pc_d = pc_q + PC_STEP;
        end else begin
            pc_d = pc_q;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (push_s),
        .pop_i       (pop_s & ~redirect_valid),
        .push_data_i (push_entry_s),
        .head_o      (head_s),
        .count_o     (count_s),
        .full_o      (full_s)
    );

    assign imem_pc  = pc_q;
    assign id_instr = head_s.instr;
    assign id_pc    = head_s.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_stage;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_instr;
    logic [15:0] id_pc;

    logic [15:0] rom [16];
    logic [31:0] mq [$];
    logic [15:0] mpc;
    logic [15:0] saved_pc;
    int          checks   = 0;
    int          failures = 0;

    fetch_stage #(.RESET_PC(16'h0000), .QDEPTH(QD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        if (a < 16'd32) return rom[a[4:1]];
        return 16'h0000;
    endfunction

    assign imem_instr = rom_word(imem_pc);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        check_eq("valid", {31'd0, id_valid}, {31'd0, (mq.size() != 0)});
        check_eq("imem_pc", {16'd0, imem_pc}, {16'd0, mpc});
        if (mq.size() != 0) begin
            check_eq("head", {id_pc, id_instr}, mq[0]);
        end
    endtask

    // One clock of stimulus; the model advances by the stage's transfer rules.
    task automatic cycle(input logic fe, input logic rv, input logic [15:0] rpc, input logic rdy);
        bit pop;
        bit push;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        pop = (mq.size() != 0) && rdy;
        if (rv) begin
            mq.delete();
            mpc = {rpc[15:1], 1'b0};
        end else begin
            push = fe && ((mq.size() < QD) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({mpc, rom_word(mpc)});
                mpc = mpc + 16'd2;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        id_ready       = 1'b0;
        mq.delete();
        mpc = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_valid", {31'd0, id_valid}, 32'd0);
        check_eq("rst_pc", {16'd0, imem_pc}, 32'h0000);
        check_eq("rst_id_instr", {16'd0, id_instr}, 32'h0000);
        check_eq("rst_id_pc", {16'd0, id_pc}, 32'h0000);
    endtask

    initial begin
        rom[0] = 16'h8080;
        rom[1] = 16'hE101;
        for (int i = 2; i < 16; i++) rom[i] = 16'(16'h1000 + i * 16'h0111);
        rst_n = 1'b0;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        id_ready = 1'b0;
        mpc = 16'h0000;

        // 1: streaming fetch after reset
        do_reset();
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("t1_pc0", {16'd0, id_pc}, 32'h0000);
        check_eq("t1_instr0", {16'd0, id_instr}, 32'h8080);
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("t1_pc2", {16'd0, id_pc}, 32'h0002);
        check_eq("t1_instr2", {16'd0, id_instr}, 32'hE101);
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("t1_pc4", {16'd0, id_pc}, 32'h0004);

        // 2: back-pressure saturates the queue, release drains without gaps
        do_reset();
        repeat (4) cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        check_eq("t2_pc_stop", {16'd0, imem_pc}, 32'h0004);
        check_eq("t2_head_hold", {16'd0, id_pc}, 32'h0000);
        check_eq("t2_valid", {31'd0, id_valid}, 32'd1);
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("t2_pop2", {16'd0, id_pc}, 32'h0002);
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("t2_pop4", {16'd0, id_pc}, 32'h0004);

        // 3: redirect while full, odd target
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 1'b1, 16'h0005, 1'b1);
        check_eq("t3_flush_valid", {31'd0, id_valid}, 32'd0);
        check_eq("t3_pc_align", {16'd0, imem_pc}, 32'h0004);
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("t3_first", {16'd0, id_pc}, 32'h0004);

        // 4: PC wrap at the top of the address space
        cycle(1'b1, 1'b1, 16'hFFFE, 1'b1);
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("t4_fffe", {16'd0, id_pc}, 32'hFFFE);
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("t4_wrap", {16'd0, id_pc}, 32'h0000);

        // 5: fetch disabled, queue drains, PC frozen
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        saved_pc = mpc;
        repeat (3) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
        check_eq("t5_drained", {31'd0, id_valid}, 32'd0);
        check_eq("t5_pc_hold", {16'd0, imem_pc}, {16'd0, saved_pc});

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [15:0] rp;
            rp = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 63)) : 16'($urandom);
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, rp,
                  $urandom_range(0, 9) < 6);
        end

        // 6: asynchronous reset between edges
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_valid", {31'd0, id_valid}, 32'd0);
        check_eq("t6_async_pc", {16'd0, imem_pc}, 32'h0000);
        mq.delete();
        mpc = 16'h0000;
        fetch_en = 1'b0;
        id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_model();
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("t6_restart", {16'd0, id_pc}, 32'h0000);
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("t6_next", {16'd0, id_pc}, 32'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
